// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and interrupt-mode encodings for gpio_irq_bank
package gpio_pkg;
  localparam int GPIO_AW = 3;
  localparam logic [GPIO_AW-1:0] GPIO_PIN   = 3'd0;
  localparam logic [GPIO_AW-1:0] GPIO_POUT  = 3'd1;
  localparam logic [GPIO_AW-1:0] GPIO_PDIR  = 3'd2;
  localparam logic [GPIO_AW-1:0] GPIO_PMODE = 3'd3;
  localparam logic [GPIO_AW-1:0] GPIO_IE    = 3'd4;
  localparam logic [GPIO_AW-1:0] GPIO_ITYPE = 3'd5;
  localparam logic [GPIO_AW-1:0] GPIO_IPOL  = 3'd6;
  localparam logic [GPIO_AW-1:0] GPIO_ISTAT = 3'd7;
  localparam logic ITYPE_LEVEL = 1'b0;
  localparam logic ITYPE_EDGE  = 1'b1;
  localparam logic IPOL_LOW    = 1'b0;
  localparam logic IPOL_HIGH   = 1'b1;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: multi-flop pad synchroniser with rise/fall detection
module gpio_sync_edge #(
  parameter int PW = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] p_in,
  output logic [PW-1:0] psync,
  output logic [PW-1:0] rise,
  output logic [PW-1:0] fall
);
  logic [SYNC_STAGES-1:0][PW-1:0] chain;
  logic [PW-1:0] pprev;
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      pprev <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], p_in};
      pprev <= chain[SYNC_STAGES-1];
    end
  end
  assign psync = chain[SYNC_STAGES-1];
  assign rise = psync & ~pprev;
  assign fall = ~psync & pprev;
endmodule

// File: rtl/gpio_irq_bank.sv
// gpio_irq_bank: Wishbone GPIO port with per-pin level/edge interrupts and one maskable IRQ
module gpio_irq_bank
  import gpio_pkg::*;
#(
  parameter int PW = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic RST_DIR = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PW-1:0]      P_in,
  output logic [PW-1:0]      D_out,
  output logic [PW-1:0]      P_dir,
  input  logic [PW-1:0]      sec_func_i,
  output logic [PW-1:0]      sec_func_o,
  output logic               IRQ,
  input  logic [GPIO_AW-1:0] WB_ADRi,
  input  logic [PW-1:0]      WB_DATi,
  output logic [PW-1:0]      WB_DATo,
  input  logic               WB_WEi,
  input  logic               WB_CYCi,
  input  logic               WB_STBi,
  output logic               WB_ACKo
);
  logic [PW-1:0] pout, pdir, pmode, ie, itype, ipol, istat;
  logic [PW-1:0] psync, rise, fall, ev, clr;
  logic [PW-1:0] regs [8];
  logic req, wr;
  gpio_sync_edge #(.PW(PW), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .p_in(P_in), .psync(psync), .rise(rise), .fall(fall)
  );
  assign req = WB_CYCi & WB_STBi & ~WB_ACKo;
  assign wr = req & WB_WEi;
  assign clr = (wr && WB_ADRi == GPIO_ISTAT) ? WB_DATi : '0;
  // Output-direction pins never raise events; level mode matches psync against IPOL
  assign ev = ~pdir & ((itype & ((ipol & rise) | (~ipol & fall))) | (~itype & ~(psync ^ ipol)));
  assign regs = '{psync, pout, pdir, pmode, ie, itype, ipol, istat};
  assign D_out = (pmode & sec_func_i) | (~pmode & pout);
  assign sec_func_o = pmode & psync;
  assign P_dir = pdir;
  always_ff @(posedge clk) begin
    if (rst) begin
      pout <= '0;
      pdir <= {PW{RST_DIR}};
      pmode <= '0;
      ie <= '0;
      itype <= '0;
      ipol <= '0;
      istat <= '0;
      IRQ <= 1'b0;
      WB_ACKo <= 1'b0;
      WB_DATo <= '0;
    end else begin
      WB_ACKo <= req;
      WB_DATo <= req ? regs[WB_ADRi] : '0;
      if (wr && WB_ADRi == GPIO_POUT) pout <= WB_DATi;
      if (wr && WB_ADRi == GPIO_PDIR) pdir <= WB_DATi;
      if (wr && WB_ADRi == GPIO_PMODE) pmode <= WB_DATi;
      if (wr && WB_ADRi == GPIO_IE) ie <= WB_DATi;
      if (wr && WB_ADRi == GPIO_ITYPE) itype <= WB_DATi;
      if (wr && WB_ADRi == GPIO_IPOL) ipol <= WB_DATi;
      istat <= (istat & ~clr) | ev;
      IRQ <= |(istat & ie);
    end
  end
endmodule

// File: tb/tb_gpio_irq_bank.sv
// tb_gpio_irq_bank: directed scenarios plus randomized traffic against a cycle reference model
module tb_gpio_irq_bank;
  localparam int PW = 8;
  localparam int S = 2;
  localparam logic RST_DIR = 1'b0;
  localparam int HN = 8192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PW-1:0] p_in = '0, sec_i = '0, dati = '0;
  logic [PW-1:0] d_out, p_dir, sec_o, dato;
  logic [2:0] adr = '0;
  logic we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic irq, ack;
  int errors = 0;
  int checks = 0;
  gpio_irq_bank #(.PW(PW), .SYNC_STAGES(S), .RST_DIR(RST_DIR)) dut (
    .clk(clk), .rst(rst), .P_in(p_in), .D_out(d_out), .P_dir(p_dir),
    .sec_func_i(sec_i), .sec_func_o(sec_o), .IRQ(irq), .WB_ADRi(adr),
    .WB_DATi(dati), .WB_DATo(dato), .WB_WEi(we), .WB_CYCi(cyc),
    .WB_STBi(stb), .WB_ACKo(ack)
  );
  always #5 clk = ~clk;
  // Reference model: pad history indexed by clock edge, registers as a plain array
  logic [PW-1:0] pin_at [HN];
  logic [PW-1:0] m_r [8];
  logic [PW-1:0] m_dato;
  logic m_ack, m_irq;
  int ecnt = 0;
  int last_rst = 0;
  function automatic logic [PW-1:0] sync_at(input int k);
    return (k > last_rst && k >= 1) ? pin_at[k % HN] : '0;
  endfunction
  function automatic logic [PW-1:0] events(input logic [PW-1:0] ps, input logic [PW-1:0] pp);
    logic [PW-1:0] e;
    for (int i = 0; i < PW; i++) begin
      if (m_r[2][i]) e[i] = 1'b0;
      else if (m_r[5][i]) e[i] = m_r[6][i] ? (ps[i] && !pp[i]) : (!ps[i] && pp[i]);
      else e[i] = (ps[i] == m_r[6][i]);
    end
    return e;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 8; i++) m_r[i] <= (i == 2) ? {PW{RST_DIR}} : '0;
      m_ack <= 1'b0;
      m_dato <= '0;
      m_irq <= 1'b0;
      last_rst <= ecnt + 1;
    end else begin
      m_ack <= cyc && stb && !m_ack;
      m_dato <= (cyc && stb && !m_ack) ? ((adr == 0) ? sync_at(ecnt + 1 - S) : m_r[adr]) : '0;
      if (cyc && stb && !m_ack && we && adr != 0 && adr != 7) m_r[adr] <= dati;
      m_r[7] <= (m_r[7] & ~((cyc && stb && !m_ack && we && adr == 7) ? dati : '0))
                | events(sync_at(ecnt + 1 - S), sync_at(ecnt - S));
      m_irq <= |(m_r[7] & m_r[4]);
    end
    pin_at[(ecnt + 1) % HN] <= p_in;
    ecnt <= ecnt + 1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic bus(input logic w, input logic [2:0] a, input logic [PW-1:0] d,
                     output logic [PW-1:0] rd, output int lat);
    if (ack) tick();
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ack && lat < 4);
    rd = dato;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  task automatic test_reset;
    logic [PW-1:0] rd, exp;
    int lat;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (ack !== 1'b0 || irq !== 1'b0 || dato !== '0) begin
      errors++; $display("FAIL reset_outs ack=%b irq=%b dato=%h want 0/0/0", ack, irq, dato);
    end
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus(1'b0, 3'(a), '0, rd, lat);
      // level-low mode with low pads flags every input pin right after reset
      exp = (a == 2) ? {PW{RST_DIR}} : (a == 7) ? {PW{~RST_DIR}} : '0;
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL reset_read[%0d] got %h want %h", a, rd, exp); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL ack_latency[%0d] got %0d want 1", a, lat); end
    end
  endtask
  task automatic test_pin;
    logic [PW-1:0] rd;
    int lat;
    bus(1'b1, 3'd2, '0, rd, lat);
    p_in = 8'hA5;
    repeat (S + 1) tick();
    bus(1'b0, 3'd0, '0, rd, lat);
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL pin_read got %h want a5", rd); end
  endtask
  task automatic test_outputs;
    logic [PW-1:0] rd;
    int lat;
    bus(1'b1, 3'd1, 8'h3C, rd, lat);
    bus(1'b1, 3'd3, 8'h0F, rd, lat);
    sec_i = 8'hFF;
    #1;
    checks++;
    if (d_out !== 8'h3F) begin errors++; $display("FAIL d_out_mux got %h want 3f", d_out); end
    checks++;
    if (sec_o !== 8'h05) begin errors++; $display("FAIL sec_func_o got %h want 05", sec_o); end
    bus(1'b1, 3'd2, 8'h5A, rd, lat);
    checks++;
    if (p_dir !== 8'h5A) begin errors++; $display("FAIL p_dir got %h want 5a", p_dir); end
    bus(1'b1, 3'd2, 8'h00, rd, lat);
    checks++;
    if (p_dir !== 8'h00) begin errors++; $display("FAIL p_dir_clear got %h want 00", p_dir); end
    bus(1'b1, 3'd5, 8'hFF, rd, lat);
    bus(1'b1, 3'd6, 8'hFF, rd, lat);
    sec_i = '0;
    p_in = '0;
    repeat (S + 2) tick();
    bus(1'b1, 3'd7, 8'hFF, rd, lat);
    bus(1'b0, 3'd7, '0, rd, lat);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL istat_clean got %h want 00", rd); end
  endtask
  task automatic test_rising;
    logic [PW-1:0] rd;
    int lat;
    bus(1'b1, 3'd4, 8'h01, rd, lat);
    p_in = 8'h01;
    repeat (3) tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early got %b want 0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq got %b want 1", irq); end
    bus(1'b0, 3'd7, '0, rd, lat);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL rise_istat got %h want 01", rd); end
    bus(1'b1, 3'd7, 8'h01, rd, lat);
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b want 0", irq); end
    bus(1'b0, 3'd7, '0, rd, lat);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL w1c_istat got %h want 00", rd); end
  endtask
  task automatic test_level;
    logic [PW-1:0] rd;
    int lat;
    bus(1'b1, 3'd2, 8'hFD, rd, lat);
    bus(1'b1, 3'd5, 8'h00, rd, lat);
    bus(1'b1, 3'd6, 8'h02, rd, lat);
    p_in = 8'h03;
    repeat (S + 2) tick();
    bus(1'b1, 3'd7, 8'hFF, rd, lat);
    bus(1'b0, 3'd7, '0, rd, lat);
    checks++;
    if (rd !== 8'h02) begin errors++; $display("FAIL level_reassert got %h want 02", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL level_masked_irq got %b want 0", irq); end
    p_in = 8'h01;
    repeat (S + 2) tick();
    bus(1'b1, 3'd7, 8'h02, rd, lat);
    bus(1'b0, 3'd7, '0, rd, lat);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL level_release got %h want 00", rd); end
  endtask
  task automatic test_mask_dir;
    logic [PW-1:0] rd;
    int lat;
    bus(1'b1, 3'd2, 8'hFF, rd, lat);
    bus(1'b1, 3'd5, 8'hFF, rd, lat);
    bus(1'b1, 3'd6, 8'hFF, rd, lat);
    bus(1'b1, 3'd7, 8'hFF, rd, lat);
    p_in = 8'h05;
    repeat (S + 2) tick();
    bus(1'b0, 3'd7, '0, rd, lat);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL dir_gate got %h want 00", rd); end
    bus(1'b1, 3'd4, 8'h00, rd, lat);
    bus(1'b1, 3'd2, 8'h00, rd, lat);
    p_in = 8'h85;
    repeat (S + 2) tick();
    bus(1'b0, 3'd7, '0, rd, lat);
    checks++;
    if (rd !== 8'h80) begin errors++; $display("FAIL ie_off_istat got %h want 80", rd); end
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ie_off_irq got %b want 0", irq); end
  endtask
  task automatic test_rst_write;
    logic [PW-1:0] rd;
    int lat;
    bus(1'b1, 3'd3, 8'h00, rd, lat);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; dati = 8'hAA; rst = 1'b1;
    tick();
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rst_write_ack got %b want 0", ack); end
    checks++;
    if (d_out !== 8'h00) begin errors++; $display("FAIL rst_write_dout got %h want 00", d_out); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
    bus(1'b0, 3'd1, '0, rd, lat);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL rst_write_pout got %h want 00", rd); end
  endtask
  task automatic test_random;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      cyc = $urandom_range(0, 1) == 1;
      stb = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 1) == 1;
      adr = 3'($urandom_range(0, 7));
      dati = PW'($urandom);
      if ($urandom_range(0, 3) == 0) p_in = PW'($urandom);
      sec_i = PW'($urandom);
      tick();
      checks++;
      if (ack !== m_ack) begin errors++; $display("FAIL rnd_ack n=%0d got %b want %b", n, ack, m_ack); end
      checks++;
      if (dato !== m_dato) begin errors++; $display("FAIL rnd_dato n=%0d got %h want %h", n, dato, m_dato); end
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq n=%0d got %b want %b", n, irq, m_irq); end
      checks++;
      if (d_out !== ((m_r[3] & sec_i) | (~m_r[3] & m_r[1]))) begin
        errors++; $display("FAIL rnd_dout n=%0d got %h want %h", n, d_out, (m_r[3] & sec_i) | (~m_r[3] & m_r[1]));
      end
      checks++;
      if (p_dir !== m_r[2]) begin errors++; $display("FAIL rnd_pdir n=%0d got %h want %h", n, p_dir, m_r[2]); end
      checks++;
      if (sec_o !== (m_r[3] & sync_at(ecnt + 1 - S))) begin
        errors++; $display("FAIL rnd_sec_o n=%0d got %h want %h", n, sec_o, m_r[3] & sync_at(ecnt + 1 - S));
      end
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  initial begin
    test_reset();
    test_pin();
    test_outputs();
    test_rising();
    test_level();
    test_mask_dir();
    test_rst_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
